// File: rtl/trigger_readout.sv
// trigger_readout: on a trigger, latches the ring buffer write address, waits for
// POST more samples, then streams PRE+POST samples (oldest first) from the ring
// buffer's two-cycle registered read port into a 4-entry queue drained by a
// valid/ready interface. Flags overrun when the writer reaches an unread address.
module trigger_readout #(
    parameter int SIZE  = 12,
    parameter int WIDTH = 14,
    parameter int PRE   = 16,
    parameter int POST  = 48
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig,
    input  logic             rb_wr_en,
    input  logic [SIZE-1:0]  rb_aout,
    input  logic [WIDTH-1:0] rb_dout,
    output logic [SIZE-1:0]  rb_ain,
    output logic             rb_rd_en,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [SIZE-1:0]  trig_addr,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = SIZE + 1;
    localparam int QD = 4;
    localparam logic [CW-1:0]   POST_C   = CW'(POST);
    localparam logic [CW-1:0]   LAST_IDX = CW'(PRE + POST - 1);
    localparam logic [SIZE-1:0] PRE_A    = SIZE'(PRE);

    typedef enum logic [1:0] {ST_IDLE, ST_POST, ST_READ, ST_DRAIN} state_t;

    state_t            state_reg;
    logic [SIZE-1:0]   start_reg;
    logic [SIZE-1:0]   rd_addr_reg;
    logic [CW-1:0]     post_cnt_reg;
    logic [CW-1:0]     issued_reg;
    logic [SIZE-1:0]   rb_ain_reg;
    logic [SIZE-1:0]   trig_addr_reg;
    logic              busy_reg;
    logic              overrun_reg;

    // Read pipeline: address on rb_ain (v0), enable on rb_rd_en, data on rb_dout (cap)
    logic              iss_v0_reg;
    logic              iss_last0_reg;
    logic              rb_rd_en_reg;
    logic              last1_reg;
    logic              cap_v_reg;
    logic              cap_last_reg;

    // Output queue
    logic [WIDTH-1:0]  q_data_reg [QD];
    logic              q_last_reg [QD];
    logic [1:0]        q_wr_reg;
    logic [1:0]        q_rd_reg;
    logic [2:0]        q_cnt_reg;

    logic              q_pop;
    logic              q_push;
    logic [3:0]        occupancy;
    logic              issue;
    logic              issue_last;
    logic              overrun_hit;
    logic              drain_done;

    // Issue control: count every slot the queue may eventually have to hold, crediting
    // the pop happening this cycle so full-rate readout is not throttled.
    always_comb begin
        q_pop       = (q_cnt_reg != 3'd0) && out_ready;
        q_push      = cap_v_reg;
        occupancy   = 4'(q_cnt_reg) - 4'(q_pop) + 4'(iss_v0_reg)
                    + 4'(rb_rd_en_reg) + 4'(cap_v_reg);
        issue       = (state_reg == ST_READ) && (occupancy < 4'd4);
        issue_last  = issue && (issued_reg == LAST_IDX);
        overrun_hit = rb_wr_en &&
                      (((state_reg == ST_POST) && (rb_aout == start_reg)) ||
                       ((state_reg == ST_READ) && (rb_aout == rd_addr_reg)));
        drain_done  = (q_cnt_reg == 3'd0) && !iss_v0_reg && !rb_rd_en_reg && !cap_v_reg;
    end

    // Control FSM: trigger capture, post-trigger wait, address issue, drain
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            start_reg     <= '0;
            rd_addr_reg   <= '0;
            post_cnt_reg  <= '0;
            issued_reg    <= '0;
            trig_addr_reg <= '0;
            busy_reg      <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (trig) begin
                        trig_addr_reg <= rb_aout;
                        start_reg     <= rb_aout - PRE_A;
                        post_cnt_reg  <= '0;
                        overrun_reg   <= 1'b0;
                        busy_reg      <= 1'b1;
                        state_reg     <= ST_POST;
                    end
                end
                ST_POST: begin
                    if (rb_wr_en) begin
                        post_cnt_reg <= post_cnt_reg + CW'(1);
                        if (post_cnt_reg + CW'(1) == POST_C) begin
                            rd_addr_reg <= start_reg;
                            issued_reg  <= '0;
                            state_reg   <= ST_READ;
                        end
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        rd_addr_reg <= rd_addr_reg + SIZE'(1);
                        issued_reg  <= issued_reg + CW'(1);
                        if (issue_last) begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_done) begin
                        busy_reg  <= 1'b0;
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
            // Only reachable in POST/READ, so never collides with the clear on trigger
            if (overrun_hit) begin
                overrun_reg <= 1'b1;
            end
        end
    end

    // Read pipeline: walk each issued address through the buffer's two-cycle latency
    always_ff @(posedge clk) begin
        if (rst) begin
            rb_ain_reg    <= '0;
            iss_v0_reg    <= 1'b0;
            iss_last0_reg <= 1'b0;
            rb_rd_en_reg  <= 1'b0;
            last1_reg     <= 1'b0;
            cap_v_reg     <= 1'b0;
            cap_last_reg  <= 1'b0;
        end else begin
            iss_v0_reg    <= issue;
            iss_last0_reg <= issue_last;
            rb_rd_en_reg  <= iss_v0_reg;
            last1_reg     <= iss_last0_reg;
            cap_v_reg     <= rb_rd_en_reg;
            cap_last_reg  <= last1_reg;
            if (issue) begin
                rb_ain_reg <= rd_addr_reg;
            end
        end
    end

    // Output queue: push returning read data, pop on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QD; i++) begin
                q_data_reg[i] <= '0;
                q_last_reg[i] <= 1'b0;
            end
            q_wr_reg  <= '0;
            q_rd_reg  <= '0;
            q_cnt_reg <= '0;
        end else begin
            if (q_push) begin
                q_data_reg[q_wr_reg] <= rb_dout;
                q_last_reg[q_wr_reg] <= cap_last_reg;
                q_wr_reg             <= q_wr_reg + 2'd1;
            end
            if (q_pop) begin
                q_rd_reg <= q_rd_reg + 2'd1;
            end
            q_cnt_reg <= q_cnt_reg + 3'(q_push) - 3'(q_pop);
        end
    end

    assign rb_ain    = rb_ain_reg;
    assign rb_rd_en  = rb_rd_en_reg;
    assign out_data  = q_data_reg[q_rd_reg];
    assign out_last  = q_last_reg[q_rd_reg];
    assign out_valid = (q_cnt_reg != 3'd0);
    assign trig_addr = trig_addr_reg;
    assign busy      = busy_reg;
    assign overrun   = overrun_reg;

endmodule

// File: tb/tb_trigger_readout.sv
// Bench for trigger_readout: two instances (PRE=3/POST=4 and PRE=12/POST=4) share one
// ring buffer writer that stores sample n = 0x100+n. The expected window is derived
// from the sample number current at the trigger, independent of read timing.
module tb_trigger_readout;

    localparam int SIZE   = 4;
    localparam int WIDTH  = 14;
    localparam int PRE_A  = 3;
    localparam int POST_A = 4;
    localparam int TOT_A  = PRE_A + POST_A;
    localparam int PRE_B  = 12;
    localparam int POST_B = 4;
    localparam int TOT_B  = PRE_B + POST_B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic trig_a = 1'b0, trig_b = 1'b0;
    logic wr_en = 1'b0;
    logic ready_a = 1'b1, ready_b = 1'b1;

    logic [SIZE-1:0]  wptr = '0;
    int               n = 0;
    logic [WIDTH-1:0] mem [16];

    logic [SIZE-1:0]  rb_ain_a, trig_addr_a, addr_q_a;
    logic [SIZE-1:0]  rb_ain_b, trig_addr_b, addr_q_b;
    logic [WIDTH-1:0] rb_dout_a, out_data_a, rb_dout_b, out_data_b;
    logic rb_rd_en_a, out_valid_a, out_last_a, busy_a, overrun_a;
    logic rb_rd_en_b, out_valid_b, out_last_b, busy_b, overrun_b;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] rec_a_d[$], rec_b_d[$];
    bit               rec_a_l[$], rec_b_l[$];
    int               addr_a[$], addr_b[$];

    bit               prev_stall_a = 1'b0;
    logic [WIDTH-1:0] prev_data_a;
    logic             prev_last_a;

    trigger_readout #(.SIZE(SIZE), .WIDTH(WIDTH), .PRE(PRE_A), .POST(POST_A)) dut_a (
        .clk(clk), .rst(rst), .trig(trig_a), .rb_wr_en(wr_en), .rb_aout(wptr),
        .rb_dout(rb_dout_a), .rb_ain(rb_ain_a), .rb_rd_en(rb_rd_en_a),
        .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(ready_a),
        .out_last(out_last_a), .trig_addr(trig_addr_a), .busy(busy_a), .overrun(overrun_a)
    );

    trigger_readout #(.SIZE(SIZE), .WIDTH(WIDTH), .PRE(PRE_B), .POST(POST_B)) dut_b (
        .clk(clk), .rst(rst), .trig(trig_b), .rb_wr_en(wr_en), .rb_aout(wptr),
        .rb_dout(rb_dout_b), .rb_ain(rb_ain_b), .rb_rd_en(rb_rd_en_b),
        .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(ready_b),
        .out_last(out_last_b), .trig_addr(trig_addr_b), .busy(busy_b), .overrun(overrun_b)
    );

    // Ring buffer: one writer, two registered read ports (address latched, then read)
    always @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= WIDTH'(32'h100 + n);
            wptr      <= wptr + 1'b1;
            n         <= n + 1;
        end
        addr_q_a <= rb_ain_a;
        if (rb_rd_en_a) rb_dout_a <= mem[addr_q_a];
        addr_q_b <= rb_ain_b;
        if (rb_rd_en_b) rb_dout_b <= mem[addr_q_b];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: record reads and accepted samples, check stall hold and queue bound
    always @(negedge clk) begin
        if (!rst && prev_stall_a)
            chk("a_stall_hold", {16'd0, out_valid_a, out_last_a, out_data_a},
                {16'd0, 1'b1, prev_last_a, prev_data_a});
        if (rb_rd_en_a) addr_a.push_back(int'(addr_q_a));
        if (out_valid_a && ready_a) begin
            rec_a_d.push_back(out_data_a);
            rec_a_l.push_back(out_last_a);
        end
        if (out_valid_a)
            chk("a_max_queued", 32'((addr_a.size() - rec_a_d.size()) > 4), 32'd0);
        prev_stall_a = !rst && out_valid_a && !ready_a;
        prev_data_a  = out_data_a;
        prev_last_a  = out_last_a;
        if (rb_rd_en_b) addr_b.push_back(int'(addr_q_b));
        if (out_valid_b && ready_b) begin
            rec_b_d.push_back(out_data_b);
            rec_b_l.push_back(out_last_b);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance the writer until it points at addr (addr<0: any) with instance A idle
    task automatic goto_addr(input int addr, input bit rnd);
        for (int k = 0; k < 100; k++) begin
            if (!busy_a && (addr < 0 || int'(wptr) == addr)) break;
            wr_en = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            step();
        end
    endtask

    task automatic check_window_a(input string tag, input int ta, input int s);
        chk({tag, "_count"}, rec_a_d.size(), TOT_A);
        for (int i = 0; i < TOT_A; i++) begin
            if (i < rec_a_d.size()) begin
                chk({tag, "_data"}, 32'(rec_a_d[i]), (32'h100 + s - PRE_A + i) & 32'h3FFF);
                chk({tag, "_last"}, 32'(rec_a_l[i]), 32'(i == TOT_A - 1));
            end
            if (i < addr_a.size())
                chk({tag, "_addr"}, addr_a[i], (ta - PRE_A + i) & 15);
        end
    endtask

    // One readout window on A. mode 0: writer always on, ready high, stray triggers;
    // mode 1: ready toggling with a 10-cycle stall; mode 2: random writer and ready.
    task automatic run_a(input string tag, input int addr, input int mode);
        int  s, ta, post_w;
        bit  w, rd_seen;
        rec_a_d.delete(); rec_a_l.delete(); addr_a.delete();
        goto_addr(addr, mode == 2);
        ta      = int'(wptr);
        s       = n;
        trig_a  = 1'b1;
        wr_en   = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        ready_a = 1'b1;
        post_w  = 0;
        rd_seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            w = wr_en;
            step();
            if (w && c > 0) post_w++;
            trig_a = 1'b0;
            if (mode == 0 && (c == 0 || (rb_rd_en_a && !rd_seen))) trig_a = 1'b1;
            if (rb_rd_en_a) rd_seen = 1'b1;
            if (mode == 0) wr_en = 1'b1;
            else if (post_w < POST_A) wr_en = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
            else wr_en = 1'b0;
            if (mode == 1) ready_a = (c >= 8 && c < 18) ? 1'b0 : c[0];
            else if (mode == 2) ready_a = ($urandom_range(0, 3) != 0);
            else ready_a = 1'b1;
            if (rec_a_d.size() >= TOT_A && !busy_a) break;
        end
        trig_a  = 1'b0;
        ready_a = 1'b1;
        chk({tag, "_idle"}, busy_a, 0);
        chk({tag, "_trig_addr"}, trig_addr_a, ta);
        chk({tag, "_overrun"}, overrun_a, 0);
        check_window_a(tag, ta, s);
        $display("window %s: trig_addr=%0d first_sample=%0d samples=%0d", tag, ta,
                 s - PRE_A, rec_a_d.size());
    endtask

    initial begin
        int ta;
        rst = 1'b1;
        repeat (3) step();
        chk("rst_valid", out_valid_a, 0);
        chk("rst_last", out_last_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_overrun", overrun_a, 0);
        chk("rst_rd_en", rb_rd_en_a, 0);
        chk("rst_ain", rb_ain_a, 0);
        chk("rst_trig_addr", trig_addr_a, 0);
        chk("rst_data", out_data_a, 0);
        chk("rst_b_busy", busy_b, 0);
        rst = 1'b0;

        run_a("t1_addr8", 8, 0);
        run_a("t2_wrap", 1, 0);
        run_a("t3_backpressure", int'($urandom_range(0, 15)), 1);
        for (int r = 0; r < 4; r++)
            run_a("t4_random", (r == 0) ? -1 : int'($urandom_range(0, 15)), 2);

        // Overrun on the full-ring instance with a long stall
        rec_b_d.delete(); rec_b_l.delete(); addr_b.delete();
        ta      = int'(wptr);
        trig_b  = 1'b1;
        wr_en   = 1'b1;
        ready_b = 1'b0;
        for (int c = 0; c < 400; c++) begin
            step();
            trig_b  = 1'b0;
            ready_b = (c >= 20);
            if (rec_b_d.size() >= TOT_B && !busy_b) break;
        end
        chk("b_idle", busy_b, 0);
        chk("b_overrun", overrun_b, 1);
        chk("b_trig_addr", trig_addr_b, ta);
        chk("b_count", rec_b_d.size(), TOT_B);
        for (int i = 0; i < TOT_B; i++) begin
            if (i < rec_b_l.size()) chk("b_last", 32'(rec_b_l[i]), 32'(i == TOT_B - 1));
            if (i < addr_b.size()) chk("b_addr", addr_b[i], (ta - PRE_B + i) & 15);
        end
        $display("window b: trig_addr=%0d samples=%0d overrun=%0d", ta, rec_b_d.size(), overrun_b);
        trig_b = 1'b1;
        step();
        trig_b = 1'b0;
        chk("b_overrun_clear", overrun_b, 0);
        chk("b_busy_again", busy_b, 1);
        for (int c = 0; c < 200; c++) begin
            if (!busy_b) break;
            step();
        end
        chk("b_second_idle", busy_b, 0);

        // Reset in the middle of a readout
        rec_a_d.delete(); rec_a_l.delete(); addr_a.delete();
        goto_addr(-1, 1'b0);
        trig_a = 1'b1;
        wr_en  = 1'b1;
        step();
        trig_a = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (rb_rd_en_a) break;
            step();
        end
        step();
        step();
        chk("rst_mid_busy_before", busy_a, 1);
        rst = 1'b1;
        step();
        chk("rst_mid_valid", out_valid_a, 0);
        chk("rst_mid_busy", busy_a, 0);
        chk("rst_mid_rd_en", rb_rd_en_a, 0);
        chk("rst_mid_trig_addr", trig_addr_a, 0);
        $display("reset mid-window: valid=%0d busy=%0d", out_valid_a, busy_a);
        rst = 1'b0;

        run_a("t5_after_rst", 5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
